// File: rtl/uart_rx_if.sv
// ---------------------------------------------------------------------------
// uart_rx_if : bundle between the UART receiver and its environment.
//
//   rx        serial line into the receiver (idle high)
//   dout      last correctly framed byte
//   rx_done   one-cycle pulse, dout just updated with a good byte
//   frame_err one-cycle pulse, stop bit was sampled low
//
// master : the side that drives the serial line and consumes the results
// slave  : the receiver itself
// ---------------------------------------------------------------------------
interface uart_rx_if #(
  parameter int DBIT = 8
);
  logic            rx;
  logic [DBIT-1:0] dout;
  logic            rx_done;
  logic            frame_err;

  modport master (output rx, input  dout, rx_done, frame_err);
  modport slave  (input  rx, output dout, rx_done, frame_err);
endinterface

// File: rtl/uart_rx.sv
// ---------------------------------------------------------------------------
// uart_rx : 8N1 UART receiver, 16x oversampling, internal baud-tick divider.
//
// Ports
//   clk      system clock, everything on posedge
//   reset    synchronous, active-high
//   rx_bus   uart_rx_if.slave : rx in; dout / rx_done / frame_err out
//
// Parameters
//   DBIT      data bits per frame (LSB first)
//   SB_TICK   oversample ticks spent in the stop bit (16 = one stop bit)
//   BAUD_DIV  clk cycles per oversample tick
//
// dout, rx_done and frame_err are registered: rx_done rises on the same
// edge that loads dout, so a consumer can latch dout on rx_done directly.
// There is no backpressure; rx_done must be taken on the cycle it is high.
// ---------------------------------------------------------------------------
module uart_rx #(
  parameter int DBIT     = 8,
  parameter int SB_TICK  = 16,
  parameter int BAUD_DIV = 326
) (
  input  logic     clk,
  input  logic     reset,
  uart_rx_if.slave rx_bus
);

  localparam int CW = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
  // s counts up to 15 in START/DATA and up to SB_TICK-1 in STOP
  localparam int SW = (SB_TICK > 16) ? $clog2(SB_TICK) : 4;
  localparam int NW = (DBIT > 1) ? $clog2(DBIT) : 1;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    WAIT_IDLE
  } state_t;

  // -------------------------------------------------------------------------
  // Input synchronizer. Both flops reset to 1 so a reset never looks like
  // a start edge.
  // -------------------------------------------------------------------------
  logic r_sync1, r_sync2;
  logic w_rx_s;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
    end else begin
      r_sync1 <= rx_bus.rx;
      r_sync2 <= r_sync1;
    end
  end

  assign w_rx_s = r_sync2;

  // -------------------------------------------------------------------------
  // Oversample tick. Free-running; deliberately not realigned on the start
  // edge, the mid-bit sampling tolerates up to one tick of phase error.
  // -------------------------------------------------------------------------
  logic [CW-1:0] r_tick_cnt;
  logic          w_tick;

  assign w_tick = (r_tick_cnt == CW'(BAUD_DIV - 1));

  always_ff @(posedge clk) begin
    if (reset)       r_tick_cnt <= '0;
    else if (w_tick) r_tick_cnt <= '0;
    else             r_tick_cnt <= r_tick_cnt + CW'(1);
  end

  // -------------------------------------------------------------------------
  // Frame FSM: state register
  // -------------------------------------------------------------------------
  state_t          r_state,     w_state;
  logic [SW-1:0]   r_s,         w_s;
  logic [NW-1:0]   r_n,         w_n;
  logic [DBIT-1:0] r_b,         w_b;
  logic [DBIT-1:0] r_dout,      w_dout;
  logic            r_rx_done,   w_rx_done;
  logic            r_frame_err, w_frame_err;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= IDLE;
      r_s         <= '0;
      r_n         <= '0;
      r_b         <= '0;
      r_dout      <= '0;
      r_rx_done   <= 1'b0;
      r_frame_err <= 1'b0;
    end else begin
      r_state     <= w_state;
      r_s         <= w_s;
      r_n         <= w_n;
      r_b         <= w_b;
      r_dout      <= w_dout;
      r_rx_done   <= w_rx_done;
      r_frame_err <= w_frame_err;
    end
  end

  // -------------------------------------------------------------------------
  // Frame FSM: next state / outputs
  // -------------------------------------------------------------------------
  always_comb begin
    w_state     = r_state;
    w_s         = r_s;
    w_n         = r_n;
    w_b         = r_b;
    w_dout      = r_dout;
    w_rx_done   = 1'b0;
    w_frame_err = 1'b0;

    unique case (r_state)
      // Falling edge seen; ticks are irrelevant until we leave IDLE.
      IDLE: begin
        if (!w_rx_s) begin
          w_state = START;
          w_s     = '0;
        end
      end

      // Wait half a bit, then confirm the line is still low. A high line
      // here was a glitch, not a start bit.
      START: begin
        if (w_tick) begin
          if (r_s == SW'(7)) begin
            if (!w_rx_s) begin
              w_state = DATA;
              w_s     = '0;
              w_n     = '0;
            end else begin
              w_state = IDLE;
            end
          end else begin
            w_s = r_s + SW'(1);
          end
        end
      end

      // Sample every 16 ticks from the start-bit midpoint, i.e. mid data bit.
      // LSB arrives first, so shift in from the top.
      DATA: begin
        if (w_tick) begin
          if (r_s == SW'(15)) begin
            w_b = {w_rx_s, r_b[DBIT-1:1]};
            w_s = '0;
            if (r_n == NW'(DBIT - 1)) w_state = STOP;
            else                      w_n = r_n + NW'(1);
          end else begin
            w_s = r_s + SW'(1);
          end
        end
      end

      // Stop bit judged at its midpoint. Returning to IDLE here (rather than
      // at the end of the stop bit) is what lets a back-to-back start edge
      // be caught.
      STOP: begin
        if (w_tick) begin
          if (r_s == SW'(SB_TICK - 1)) begin
            if (w_rx_s) begin
              w_dout    = r_b;
              w_rx_done = 1'b1;
              w_state   = IDLE;
            end else begin
              w_frame_err = 1'b1;
              w_state     = WAIT_IDLE;
            end
          end else begin
            w_s = r_s + SW'(1);
          end
        end
      end

      // A line held low (break) must not look like an endless run of frames.
      WAIT_IDLE: begin
        if (w_rx_s) w_state = IDLE;
      end

      default: w_state = IDLE;
    endcase
  end

  assign rx_bus.dout      = r_dout;
  assign rx_bus.rx_done   = r_rx_done;
  assign rx_bus.frame_err = r_frame_err;

endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
- 8N1 UART receiver with 16x oversampling and an internal baud-tick generator.
- Sits directly upstream of the 5-byte receive buffer.
- Each correctly framed byte is presented on dout, with a one-cycle rx_done pulse that drives the buffer's write strobe.
- Bad frames are flagged and never forwarded.

Parameters:
DBIT, 8, data bits per frame, LSB first.
SB_TICK, 16, oversample ticks spent in the stop bit (16 = 1 stop bit).
BAUD_DIV, 326, clk cycles per oversample tick (50 MHz / (9600*16), rounded).

Ports:
clk  input  1  system clock; all logic on posedge.
reset  input  1  synchronous, active-high reset.
rx  input  1  asynchronous serial line, idle high.
dout  output  8  last correctly received byte; holds until the next good byte.
rx_done  output  1  one-cycle pulse when dout is updated with a good byte.
frame_err  output  1  one-cycle pulse when the stop bit is sampled low.

Behaviour:
- Reset (synchronous, active-high) values:
  - state=IDLE; tick counter=0; s=0, n=0; shift reg b=0.
  - dout=0, rx_done=0, frame_err=0.
  - Both synchronizer flops = 1 (idle line).
- Input sync: rx passes through 2 flops to give rx_s. All FSM decisions use rx_s only (2-cycle latency).
- Tick generator:
  - Free-running counter 0..BAUD_DIV-1; tick=1 for one clk when counter==BAUD_DIV-1, then counter wraps to 0.
  - Not realigned on start-bit detection; start-edge jitter of up to 1 tick is accepted.
- State IDLE: when rx_s==0, go to START with s=0. Ticks are ignored.
- State START, on each tick:
  - s==7 (mid start bit): if rx_s==0, go to DATA with s=0, n=0.
  - s==7 and rx_s==1: glitch; return to IDLE, no output.
  - Otherwise s++.
- State DATA, on each tick:
  - s==15: b <= {rx_s, b[7:1]}, s=0.
  - If n==DBIT-1, go to STOP; else n++.
  - Otherwise s++.
- State STOP, on each tick:
  - s==SB_TICK-1, rx_s==1: dout<=b, rx_done=1 for this cycle, go to IDLE.
  - s==SB_TICK-1, rx_s==0: frame_err=1 for this cycle, dout unchanged, go to WAIT_IDLE.
  - Otherwise s++.
- State WAIT_IDLE: stay until rx_s==1, then go to IDLE. This prevents a held-low line (break) from retriggering frames.
- Timing:
  - rx_done fires at the middle of the stop bit: about 9.5 bit periods after the start falling edge, plus 2 sync cycles.
  - rx_done and frame_err are mutually exclusive and never asserted on consecutive cycles.
- Back-to-back frames: a start edge immediately after the stop-bit mid-point must be caught. IDLE is re-entered the cycle after rx_done.
- Reset mid-frame: the frame is abandoned with no rx_done or frame_err, and all state returns to reset values on the next clk.
- Downstream has no backpressure. The consumer must accept rx_done on the cycle it is asserted.

Test Plan:
All scenarios use BAUD_DIV=4, giving a bit period of 64 clk.
- Reset then idle-high rx for 1000 clk -> dout=0x00, rx_done and frame_err never asserted.
- Send 0xA5 (8N1) -> exactly one rx_done pulse, 606-614 clk after the start edge; dout=0xA5; frame_err stays 0.
- Send 0x3C, 0xFF, 0x00, 0x81, 0x5A back-to-back, no idle gap -> 5 rx_done pulses; dout sequence matches. Driving the 5-byte buffer sets full after the 5th byte.
- Send 0x55 with stop bit forced low, then hold rx low for 20 bit periods, then release -> one frame_err pulse; dout keeps its previous value; no further pulses until a new frame arrives after release. The following 0x12 is received correctly.
- 2-tick (8 clk) low glitch on idle rx -> no rx_done or frame_err; a subsequent 0xC3 is received correctly.
- Assert reset during data bit 4 of a frame, release, then send 0x7E -> no pulse for the aborted frame; dout=0x7E after the new frame.
